// File: rtl/fixed_addsub_pipe.sv
// Two-stage pipelined signed fixed-point adder/subtractor with configurable
// output format, optional round-half-up and saturation, and valid/ready flow control.
module fixed_addsub_pipe #(
  parameter int WI1 = 4,
  parameter int WF1 = 3,
  parameter int WI2 = 6,
  parameter int WF2 = 2,
  parameter int WIO = 9,
  parameter int WFO = 5,
  parameter int SAT = 1,
  parameter int RND = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WI1+WF1-1:0]   in1,
  input  logic [WI2+WF2-1:0]   in2,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIO+WFO-1:0]   out,
  output logic                 ovf,
  output logic                 ovf_sticky,
  input  logic                 ovf_clr
);

  localparam int WII  = ((WI1 > WI2) ? WI1 : WI2) + 1;
  localparam int WFI  = (WF1 > WF2) ? WF1 : WF2;
  localparam int WINT = WII + WFI;
  localparam int WFX  = (WFO > WFI) ? WFO : WFI;
  localparam int WX   = WII + 1 + WFX;
  localparam int WO   = WIO + WFO;
  localparam int WC   = ((WX > WO) ? WX : WO) + 1;
  localparam int DROP = WFX - WFO;
  localparam int RSH  = (DROP > 0) ? DROP - 1 : 0;

  localparam logic signed [WX-1:0] RND_ADD =
    (RND != 0 && DROP > 0) ? (WX'(1) <<< RSH) : '0;
  localparam logic signed [WC-1:0] MAX_V = {{(WC-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [WC-1:0] MIN_V = {{(WC-WO+1){1'b1}}, {(WO-1){1'b0}}};

  logic                   s1_valid_q, s1_valid_d;
  logic                   s2_valid_q, s2_valid_d;
  logic signed [WINT-1:0] sum_q, sum_d;
  logic [WO-1:0]          out_q, out_d;
  logic                   ovf_q, ovf_d;
  logic                   ovf_sticky_q, ovf_sticky_d;

  logic                   s2_adv, s1_adv, accept;
  logic signed [WINT-1:0] a1, a2;
  logic signed [WX-1:0]   ext, rnd;
  logic signed [WC-1:0]   red;
  logic                   ovf_c;
  logic [WO-1:0]          out_c;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = rst && s1_adv;
    accept   = in_valid && in_ready;
  end

  // Internal format has one extra integer bit so the exact sum cannot overflow.
  always_comb begin
    a1    = WINT'($signed(in1)) <<< (WFI - WF1);
    a2    = WINT'($signed(in2)) <<< (WFI - WF2);
    sum_d = sum_q;
    if (accept) begin
      sum_d = sub ? (a1 - a2) : (a1 + a2);
    end
  end

  // Guard integer bit in ext absorbs the rounding increment.
  always_comb begin
    ext   = WX'(sum_q) <<< (WFX - WFI);
    rnd   = ext + RND_ADD;
    red   = WC'(rnd >>> DROP);
    ovf_c = (red > MAX_V) || (red < MIN_V);
    out_c = red[WO-1:0];
    if (SAT != 0 && ovf_c) begin
      out_c = red[WC-1] ? MIN_V[WO-1:0] : MAX_V[WO-1:0];
    end
  end

  always_comb begin
    s1_valid_d   = s1_adv ? accept : s1_valid_q;
    s2_valid_d   = s2_adv ? s1_valid_q : s2_valid_q;
    out_d        = out_q;
    ovf_d        = ovf_q;
    if (s2_adv && s1_valid_q) begin
      out_d = out_c;
      ovf_d = ovf_c;
    end
    ovf_sticky_d = ovf_sticky_q;
    if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
    end
    if (s2_valid_q && out_ready && ovf_q) begin
      ovf_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_q        <= '0;
      ovf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      out_q        <= out_d;
      ovf_q        <= ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    sum_q <= sum_d;
  end

  assign out_valid  = s2_valid_q;
  assign out        = out_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_fixed_addsub_pipe.sv
// Directed vector bench: one default instance plus two Q5.2 instances
// (saturate+round and wrap+truncate) driven by the same operand stream.
module tb_fixed_addsub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [6:0]  in1;
  logic [7:0]  in2;
  logic        sub;
  logic        out_ready;
  logic        ovf_clr;

  logic        m_in_ready, m_out_valid, m_ovf, m_sticky;
  logic [13:0] m_out;
  logic        a_in_ready, a_out_valid, a_ovf, a_sticky;
  logic [6:0]  a_out;
  logic        b_in_ready, b_out_valid, b_ovf, b_sticky;
  logic [6:0]  b_out;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [6:0]  in1;
    logic [7:0]  in2;
    logic        sub;
    logic [13:0] m_out;
    logic        m_ovf;
    logic [6:0]  a_out;
    logic        a_ovf;
    logic [6:0]  b_out;
    logic        b_ovf;
  } vec_t;

  vec_t tbl[9];

  fixed_addsub_pipe dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .in1(in1), .in2(in2), .sub(sub), .out_valid(m_out_valid),
    .out_ready(out_ready), .out(m_out), .ovf(m_ovf),
    .ovf_sticky(m_sticky), .ovf_clr(ovf_clr)
  );

  fixed_addsub_pipe #(.WIO(5), .WFO(2), .SAT(1), .RND(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in1(in1), .in2(in2), .sub(sub), .out_valid(a_out_valid),
    .out_ready(out_ready), .out(a_out), .ovf(a_ovf),
    .ovf_sticky(a_sticky), .ovf_clr(ovf_clr)
  );

  fixed_addsub_pipe #(.WIO(5), .WFO(2), .SAT(0), .RND(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in1(in1), .in2(in2), .sub(sub), .out_valid(b_out_valid),
    .out_ready(out_ready), .out(b_out), .ovf(b_ovf),
    .ovf_sticky(b_sticky), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int idx);
    in_valid = 1'b1;
    in1      = tbl[idx].in1;
    in2      = tbl[idx].in2;
    sub      = tbl[idx].sub;
  endtask

  task automatic check_vec(input string tag, input int idx);
    check({tag, "_valid"}, 32'(m_out_valid), 32'(1'b1));
    check({tag, "_m_out"}, 32'(m_out), 32'(tbl[idx].m_out));
    check({tag, "_m_ovf"}, 32'(m_ovf), 32'(tbl[idx].m_ovf));
    check({tag, "_a_valid"}, 32'(a_out_valid), 32'(1'b1));
    check({tag, "_a_out"}, 32'(a_out), 32'(tbl[idx].a_out));
    check({tag, "_a_ovf"}, 32'(a_ovf), 32'(tbl[idx].a_ovf));
    check({tag, "_b_out"}, 32'(b_out), 32'(tbl[idx].b_out));
    check({tag, "_b_ovf"}, 32'(b_ovf), 32'(tbl[idx].b_ovf));
  endtask

  // Accept one operand into an empty pipe and confirm the two-cycle latency.
  task automatic send(input string tag, input int idx);
    drive(idx);
    check({tag, "_in_ready"}, 32'(m_in_ready), 32'(1'b1));
    step();
    in_valid = 1'b0;
    check({tag, "_early_valid"}, 32'(m_out_valid), 32'(1'b0));
    step();
    check_vec(tag, idx);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // in1 Q4.3, in2 Q6.2; m = Q9.5 default, a = Q5.2 sat+round, b = Q5.2 wrap+floor
    tbl[0] = '{7'h3F, 8'h7F, 1'b0, 14'h04F4, 1'b0, 7'h3F, 1'b1, 7'h1E, 1'b1};
    tbl[1] = '{7'h40, 8'h7F, 1'b1, 14'h3B08, 1'b0, 7'h40, 1'b1, 7'h61, 1'b1};
    tbl[2] = '{7'h01, 8'h00, 1'b0, 14'h0004, 1'b0, 7'h01, 1'b0, 7'h00, 1'b0};
    tbl[3] = '{7'h7F, 8'h00, 1'b0, 14'h3FFC, 1'b0, 7'h00, 1'b0, 7'h7F, 1'b0};
    tbl[4] = '{7'h0C, 8'h09, 1'b1, 14'h3FE8, 1'b0, 7'h7D, 1'b0, 7'h7D, 1'b0};
    tbl[5] = '{7'h1B, 8'hF8, 1'b0, 14'h002C, 1'b0, 7'h06, 1'b0, 7'h05, 1'b0};
    tbl[6] = '{7'h01, 8'h3F, 1'b0, 14'h01FC, 1'b0, 7'h3F, 1'b1, 7'h3F, 1'b0};
    tbl[7] = '{7'h00, 8'hC0, 1'b0, 14'h3E00, 1'b0, 7'h40, 1'b0, 7'h40, 1'b0};
    tbl[8] = '{7'h7F, 8'hC0, 1'b0, 14'h3DFC, 1'b0, 7'h40, 1'b0, 7'h3F, 1'b1};

    rst       = 1'b0;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    #3;
    check("rst_out_valid", 32'(m_out_valid), 32'(1'b0));
    check("rst_in_ready", 32'(m_in_ready), 32'(1'b0));
    check("rst_out", 32'(m_out), 32'(0));
    check("rst_sticky", 32'(m_sticky), 32'(1'b0));
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    check("rel_in_ready", 32'(m_in_ready), 32'(1'b1));
    step();
    check("rel_in_ready_cycle", 32'(m_in_ready), 32'(1'b1));
    check("rel_out_valid", 32'(m_out_valid), 32'(1'b0));

    // Back-to-back stream: vector i-1 must be on out right after vector i is accepted.
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) begin
        drive(i);
        check("stream_in_ready", 32'(m_in_ready), 32'(1'b1));
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1) check_vec("stream", i - 1);
    end
    step();
    check("stream_drained", 32'(m_out_valid), 32'(1'b0));
    check("stream_sticky_m", 32'(m_sticky), 32'(1'b0));
    check("stream_sticky_a", 32'(a_sticky), 32'(1'b1));
    check("stream_sticky_b", 32'(b_sticky), 32'(1'b1));

    // Clear held high across a delivered overflow: set must win.
    ovf_clr = 1'b1;
    step();
    check("clr_sticky_a", 32'(a_sticky), 32'(1'b0));
    send("setwin", 0);
    check("setwin_pre_sticky", 32'(a_sticky), 32'(1'b0));
    step();
    check("setwin_sticky_a", 32'(a_sticky), 32'(1'b1));
    check("setwin_sticky_m", 32'(m_sticky), 32'(1'b0));
    step();
    check("setwin_then_clr", 32'(a_sticky), 32'(1'b0));
    ovf_clr = 1'b0;

    // Stall with continuous offers: only two get in, out holds the first.
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(c + 2);
      check("stall_in_ready", 32'(m_in_ready), (c < 2) ? 32'd1 : 32'd0);
      step();
      if (c >= 1) check_vec("stall_hold", 2);
    end
    check("stall_in_ready_end", 32'(m_in_ready), 32'(1'b0));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_vec("drain_first", 2);
    step();
    check_vec("drain_second", 3);
    step();
    check("drain_empty", 32'(m_out_valid), 32'(1'b0));

    // Reset with two results in flight and the sticky flag set.
    send("pre_rst", 0);
    step();
    check("pre_rst_sticky", 32'(a_sticky), 32'(1'b1));
    out_ready = 1'b0;
    drive(1);
    step();
    drive(2);
    step();
    in_valid = 1'b0;
    check("full_out_valid", 32'(m_out_valid), 32'(1'b1));
    check("full_in_ready", 32'(m_in_ready), 32'(1'b0));
    #2;
    rst = 1'b0;
    #1;
    check("async_out_valid", 32'(m_out_valid), 32'(1'b0));
    check("async_sticky_a", 32'(a_sticky), 32'(1'b0));
    check("async_out_m", 32'(m_out), 32'(0));
    check("async_out_a", 32'(a_out), 32'(0));
    check("async_ovf_a", 32'(a_ovf), 32'(1'b0));
    check("async_in_ready", 32'(m_in_ready), 32'(1'b0));
    #3;
    rst = 1'b1;
    step();
    check("post_rst_valid", 32'(m_out_valid), 32'(1'b0));
    out_ready = 1'b1;
    send("post_rst", 5);
    step();
    check("post_rst_empty", 32'(m_out_valid), 32'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_addsub_pipe.md
FIXED_ADDSUB_PIPE -- requirements
Module: fixed_addsub_pipe

Interface
REQ-001 SHALL have parameters: WI1, default 4, integer bits of in1 (sign included); WF1, default 3, fraction bits of in1.
REQ-002 SHALL have parameters: WI2, default 6, integer bits of in2; WF2, default 2, fraction bits of in2.
REQ-003 SHALL have parameters: WIO, default 9, output integer bits; WFO, default 5, output fraction bits.
REQ-004 SHALL have parameters: SAT, default 1, 1 = saturate on overflow, 0 = wrap; RND, default 0, 1 = round-half-up, 0 = truncate (floor).
REQ-005 SHALL have one clock, clk, and an asynchronous active-low reset, rst.
REQ-006 Ports: clk  in  1  clock; rst  in  1  async active-low reset.
REQ-007 Ports: in_valid  in  1  operand valid; in_ready  out  1  operand accepted when in_valid&in_ready at posedge clk.
REQ-008 Ports: in1  in  WI1+WF1  signed Q(WI1.WF1); in2  in  WI2+WF2  signed Q(WI2.WF2); sub  in  1  0 = in1+in2, 1 = in1-in2.
REQ-009 Ports: out_valid  out  1; out_ready  in  1; out  out  WIO+WFO  signed Q(WIO.WFO); ovf  out  1  per-result overflow, aligned with out.
REQ-010 Ports: ovf_sticky  out  1  set by any delivered overflow; ovf_clr  in  1  synchronous clear of ovf_sticky.

Function
REQ-011 SHALL align operands to internal format WIint = max(WI1,WI2)+1, WFint = max(WF1,WF2): sign-extend the integer part, zero-pad the fraction.
REQ-012 SHALL compute the exact sum or difference (per sub) in the internal format; no overflow possible internally.
REQ-013 Fraction reduction when WFO < WFint: RND=0 floors (drops LSBs); RND=1 adds 2^-(WFO+1) before dropping, with one guard integer bit; when WFO >= WFint, zero-pad.
REQ-014 Integer reduction: ovf=1 iff the rounded value lies outside [-2^(WIO-1), 2^(WIO-1) - 2^-WFO]; SAT=1 clamps to that bound; SAT=0 keeps the low WIO+WFO bits.
REQ-015 SHALL be a 2-stage pipeline: stage 1 registers the aligned add/sub; stage 2 registers the rounded, reduced out and ovf.
REQ-016 Latency: a result SHALL appear on out with out_valid=1 two cycles after acceptance when not stalled; throughput 1/cycle while out_ready=1.
REQ-017 Stage 2 advances when !s2_valid or out_ready; stage 1 advances when !s1_valid or stage 2 advances; in_ready = !s1_valid or stage 1 advances (combinational from out_ready permitted).
REQ-018 While out_valid=1 and out_ready=0, out and ovf SHALL hold stable; no result SHALL be lost, duplicated or reordered; capacity 2 results.
REQ-019 in1, in2 and sub SHALL be ignored when not accepted.
REQ-020 ovf_sticky SHALL set in the cycle a result with ovf=1 is delivered (out_valid&out_ready); it SHALL clear on ovf_clr; set wins on simultaneous set and clear.

Reset
REQ-021 rst low SHALL immediately force out_valid=0, ovf=0, ovf_sticky=0, out=0 and both stage valids=0, discarding in-flight results.
REQ-022 in_ready SHALL be 0 while rst is low and 1 in the first cycle after release; data registers need no reset beyond out.

Verification
REQ-023 Defaults; in1=0111_111 (7.875), in2=011111_11 (31.75), sub=0, out_ready=1 -> two cycles later out=14'h04F4 (39.625), ovf=0.
REQ-024 Defaults; in1=1000_000 (-8), in2=011111_11, sub=1 -> out=14'h3B08 (-39.75), ovf=0.
REQ-025 WIO=5, WFO=2, SAT=1; 7.875+31.75 -> out=7'b0111111 (15.75), ovf=1, ovf_sticky=1; SAT=0 -> out=7'b0011110 (7.5), ovf=1.
REQ-026 WIO=5, WFO=2; in1=0000_001 (0.125), in2=0: RND=1 -> out=7'b0000001, RND=0 -> 0. in1=1111_111 (-0.125): RND=1 -> 0, RND=0 -> 7'b1111111.
REQ-027 out_ready=0 for 5 cycles with in_valid=1 continuously -> exactly 2 accepted, then in_ready=0 and out stable; after out_ready=1, results delivered in order with none lost.
REQ-028 rst low with 2 results in flight and ovf_sticky=1 -> out_valid=0 and ovf_sticky=0 at once; after release, the first new operand delivers two cycles after acceptance.
